// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, addresses instr_mem, and registers the returned word with its PC.
// Handles stall, jump/branch redirects (one-slot squash) and a terminal halt past the program end.
module instr_fetch #(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned NUM_INSTR = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc_out_d;
  logic [31:0]      instr_d;
  logic             valid_d;
  logic             halted_d;
  logic [CNT_W-1:0] count_d;

  logic [31:0]      link_pc;
  logic [31:0]      branch_pc;
  logic [31:0]      jump_pc;
  logic             past_end;
  logic [CNT_W-1:0] count_inc;

  // Redirect targets are relative to the instruction currently presented downstream.
  assign link_pc   = pc_out + 32'd4;
  assign branch_pc = link_pc + 32'(branch_offset << 2);
  assign jump_pc   = {link_pc[31:28], jump_target, 2'b00};
  assign past_end  = (pc_q[31:2] >= 30'(NUM_INSTR));
  assign count_inc = (fetch_count == {CNT_W{1'b1}}) ? fetch_count : fetch_count + CNT_W'(1);

  assign imem_addr = pc_q[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pc_out      <= 32'd0;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out      <= pc_out_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
      halted      <= halted_d;
      fetch_count <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out;
    instr_d  = instr;
    valid_d  = instr_valid;
    halted_d = halted;
    count_d  = fetch_count;

    case (state_q)
      IDLE: state_d = RUN;

      RUN: begin
        if (!stall) begin
          if (jump) begin
            pc_d    = jump_pc;
            valid_d = 1'b0;
          end else if (branch_taken) begin
            pc_d    = branch_pc;
            valid_d = 1'b0;
          end else if (past_end) begin
            state_d  = HALT;
            valid_d  = 1'b0;
            halted_d = 1'b1;
          end else begin
            instr_d  = imem_rd;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
            count_d  = count_inc;
          end
        end
      end

      HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a cycle-level reference model pushes expected
// outputs per clock; an independent monitor pops and compares after each rising edge.
module tb_instr_fetch;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned NUM_INSTR = 18;
  localparam int unsigned N_CYC     = 3000;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall;
  logic              branch_taken;
  logic [31:0]       branch_offset;
  logic              jump;
  logic [25:0]       jump_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rd;
  logic [31:0]       pc_out;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              halted;
  logic [15:0]       fetch_count;

  logic [31:0] mem [64];

  assign imem_rd = mem[imem_addr];

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0),
    .NUM_INSTR(NUM_INSTR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .pc_out       (pc_out),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  typedef struct {
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [15:0] count;
    logic [5:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   passed = 0;

  // Reference model: what the fetch stage is holding/presenting right now.
  logic        m_wait;
  logic        m_halted;
  logic [31:0] m_pc;
  logic [31:0] m_pc_out;
  logic [31:0] m_instr;
  logic        m_valid;
  int unsigned m_count;

  logic        s_rst, s_stall, s_br, s_jmp;
  logic [31:0] s_off;
  logic [25:0] s_tgt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  task automatic model_step();
    if (s_rst) begin
      m_wait = 1'b1; m_halted = 1'b0; m_pc = 32'h0; m_pc_out = 32'h0;
      m_instr = 32'h0; m_valid = 1'b0; m_count = 0;
    end else if (m_wait) begin
      m_wait = 1'b0;
    end else if (m_halted || s_stall) begin
      m_valid = m_halted ? 1'b0 : m_valid;
    end else if (s_jmp) begin
      m_pc    = ((m_pc_out + 32'd4) & 32'hF000_0000) | {4'h0, s_tgt, 2'b00};
      m_valid = 1'b0;
    end else if (s_br) begin
      m_pc    = m_pc_out + 32'd4 + s_off * 32'd4;
      m_valid = 1'b0;
    end else if ((m_pc / 4) >= NUM_INSTR) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else begin
      m_instr  = mem[m_pc / 4];
      m_pc_out = m_pc;
      m_valid  = 1'b1;
      m_pc     = m_pc + 32'd4;
      if (m_count < 65535) m_count++;
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc_out",      pc_out,               e.pc_out);
        check("instr",       instr,                e.instr);
        check("instr_valid", 32'(instr_valid),     32'(e.valid));
        check("halted",      32'(halted),          32'(e.halted));
        check("fetch_count", 32'(fetch_count),     32'(e.count));
        check("imem_addr",   32'(imem_addr),       32'(e.addr));
      end
    end
  end

  // Stimulus: directed startup/run-to-halt, then randomized stall/redirect/reset traffic.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_offset = 32'h0; jump_target = 26'h0;
    m_wait = 1'b1; m_halted = 1'b0; m_pc = 32'h0; m_pc_out = 32'h0;
    m_instr = 32'h0; m_valid = 1'b0; m_count = 0;

    for (int cyc = 0; cyc < int'(N_CYC); cyc++) begin
      @(negedge clk);
      s_rst = 1'b0; s_stall = 1'b0; s_br = 1'b0; s_jmp = 1'b0;
      s_off = 32'h0; s_tgt = 26'h0;
      if (cyc < 2 || cyc == 40) begin
        s_rst = 1'b1;
      end else if (cyc > 41) begin
        s_rst   = ($urandom_range(0, 99) < (m_halted ? 20 : 1));
        s_stall = ($urandom_range(0, 99) < 20);
        s_br    = ($urandom_range(0, 99) < 10);
        s_jmp   = ($urandom_range(0, 99) < 5);
        s_off   = ($urandom_range(0, 7) == 0) ? 32'h1000_0000
                                              : 32'(int'($urandom_range(0, 40)) - 20);
        s_tgt   = 26'($urandom_range(0, 22));
      end
      reset = s_rst; stall = s_stall; branch_taken = s_br; jump = s_jmp;
      branch_offset = s_off; jump_target = s_tgt;
      model_step();
      exp_q.push_back('{pc_out: m_pc_out, instr: m_instr, valid: m_valid,
                        halted: m_halted, count: 16'(m_count), addr: m_pc[7:2]});
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
